// File: rtl/counter_modulo_n_decoder.sv
// counter_modulo_n_decoder: loadable up/down modulo-N counter with one-hot decode and wrap flags
module counter_modulo_n_decoder #(
  parameter int WIDTH          = 3,
  parameter int MODULUS        = 8,
  parameter bit DEC_ACTIVE_LOW = 1'b0
) (
  input  logic               clockpulse,
  input  logic               clear,
  input  logic               enable,
  input  logic               up_down,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_value,
  output logic [WIDTH-1:0]   counter_out,
  output logic [MODULUS-1:0] decoder_out,
  output logic               terminal_count,
  output logic               wrap_pulse
);
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("MODULUS must lie in 2..2**WIDTH");
  end
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0]   r_count;
  logic               r_wrap;
  logic [WIDTH-1:0]   w_next;
  logic [WIDTH-1:0]   w_load;
  logic               w_tc;
  logic [MODULUS-1:0] w_onehot;
  // out-of-range load values saturate to the top of the sequence
  always_comb begin
    w_load = ({1'b0, load_value} >= (WIDTH+1)'(MODULUS)) ? MAX : load_value;
    w_tc   = enable & ~load & ~clear & (up_down ? (r_count == MAX) : (r_count == '0));
    w_next = up_down ? ((r_count == MAX) ? '0 : r_count + 1'b1)
                     : ((r_count == '0) ? MAX : r_count - 1'b1);
    w_onehot = {{(MODULUS-1){1'b0}}, 1'b1} << r_count;
  end
  // count register with clear > load > enable > hold priority; wrap flag follows terminal count
  always_ff @(posedge clockpulse) begin
    if (clear) r_count <= '0;
    else if (load) r_count <= w_load;
    else if (enable) r_count <= w_next;
    r_wrap <= w_tc;
  end
  assign counter_out    = r_count;
  assign decoder_out    = DEC_ACTIVE_LOW ? ~w_onehot : w_onehot;
  assign terminal_count = w_tc;
  assign wrap_pulse     = r_wrap;
endmodule

// File: doc/counter_modulo_n_decoder.md
COUNTER_MODULO_N_DECODER -- requirements
Module: counter_modulo_n_decoder

Interface
REQ-001 Parameter WIDTH, default 3; count register width in bits.
REQ-002 Parameter MODULUS, default 8; count sequence length; legal range 2..2^WIDTH; elaboration SHALL fail outside this range.
REQ-003 Parameter DEC_ACTIVE_LOW, default 0; 1 SHALL invert decoder_out polarity.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, as the next two ports.
REQ-005 clockpulse  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 clear  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  count advance enable.
REQ-008 up_down  input  1  direction; 1 = up, 0 = down.
REQ-009 load  input  1  synchronous parallel-load request.
REQ-010 load_value  input  WIDTH  value to load.
REQ-011 counter_out  output  WIDTH  registered count.
REQ-012 decoder_out  output  MODULUS  one-hot decode of counter_out.
REQ-013 terminal_count  output  1  combinational; next enabled step wraps.
REQ-014 wrap_pulse  output  1  registered; one-cycle flag that a wrap occurred.

Function
REQ-015 Per-edge priority SHALL be clear > load > enable > hold.
REQ-016 Up step: count+1; at MODULUS-1 the next count SHALL be 0.
REQ-017 Down step: count-1; at 0 the next count SHALL be MODULUS-1.
REQ-018 Load: load_value < MODULUS SHALL be taken as-is; load_value >= MODULUS SHALL load MODULUS-1.
REQ-019 enable=0 and load=0: count and wrap_pulse=0 SHALL hold / deassert.
REQ-020 decoder_out bit[counter_out] SHALL be active, all other bits inactive; zero latency from counter_out, no extra register.
REQ-021 terminal_count SHALL be 1 iff enable=1, load=0, clear=0, and count = MODULUS-1 with up_down=1, or count = 0 with up_down=0.
REQ-022 wrap_pulse SHALL be 1 in the cycle after an edge at which terminal_count was 1; otherwise 0.
REQ-023 Load coincident with enable SHALL NOT produce wrap_pulse, even when the load value equals the wrap target.
REQ-024 up_down may change on any cycle; the next step SHALL use the value sampled at that edge, with no dead cycle.
REQ-025 counter_out SHALL never hold a value >= MODULUS after any edge.
REQ-026 MODULUS = 2^WIDTH SHALL use natural binary wrap with identical external behaviour.

Reset
REQ-027 clear=1 at an edge SHALL set counter_out=0, wrap_pulse=0, and decoder_out bit0 active; it overrides load and enable.
REQ-028 clear asserted mid-count SHALL take effect at the next edge, with no partial step.
REQ-029 Before the first clear, outputs are undefined; the bench SHALL apply clear for >= 1 cycle.

Verification
REQ-030 Defaults; clear 1 cycle, enable=1, up_down=1 for 9 cycles -> counter_out 1..7,0,1; decoder_out 0x02..0x80,0x01,0x02; wrap_pulse high only in the cycle showing 0.
REQ-031 WIDTH=3, MODULUS=6, down from 0 -> counter_out 5,4,3,2,1,0,5; terminal_count high when count=0; decoder_out 6'b100000 after wrap.
REQ-032 MODULUS=6; load=1, load_value=7 -> counter_out=5; load=1 with enable=1 at count 5, load_value=0 -> counter_out=0, wrap_pulse stays 0.
REQ-033 Count at 3, assert clear together with load=1 (load_value=6) and enable=1 -> counter_out=0, decoder_out=0x01, wrap_pulse=0.
REQ-034 Defaults at count 4; toggle up_down each cycle with enable=1 -> counter_out 5,4,5,4; enable=0 -> holds.
REQ-035 DEC_ACTIVE_LOW=1, count=2 -> decoder_out=8'hFB; after clear -> 8'hFE.
